kbd_event_ctrl: RTL
===================

Name: kbd_event_ctrl

Overview:
- Sequences the raw byte stream from the keyboard serial receiver (NEW_CODE/CODE) into complete key events.
- Decodes the E0 (extended), F0 (break) and E1 (pause) prefix sequences; filters typematic repeats and discards protocol/status bytes.
- Buffers decoded events in a small FIFO, read by the consumer through a valid/ready handshake.
- Sits between the receiver and application logic (display, character mapper).

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, ≥2.
- TIMEOUT_CYC, 1000000, CLK cycles allowed between bytes of one multi-byte sequence (20 ms at 50 MHz).
- FILTER_REPEAT, 1, 1 = suppress a make event identical to the last unreleased make.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-low.
- NEW_CODE  in  1  one-CLK pulse: CODE holds a valid received byte.
- CODE  in  8  received byte, valid when NEW_CODE=1.
- EVT_READY  in  1  consumer accepts the head event this cycle.
- EVT_VALID  out  1  FIFO non-empty; EVT_* fields valid.
- EVT_CODE  out  8  key code of the head event.
- EVT_EXT  out  1  head event was E0-prefixed (or pause).
- EVT_RELEASE  out  1  head event is a break (release).
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current number of stored events.
- OVERFLOW  out  1  sticky: an event was dropped because the FIFO was full.
- TIMEOUT_ERR  out  1  sticky: a partial sequence was aborted on timeout.
- CLR_ERR  in  1  synchronous clear of OVERFLOW and TIMEOUT_ERR.

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM goes to IDLE.
  - FIFO is emptied; EVT_VALID=0, FIFO_LEVEL=0.
  - EVT_CODE, EVT_EXT and EVT_RELEASE read 0.
  - OVERFLOW=0, TIMEOUT_ERR=0; repeat-filter register cleared (no key held).
  - Reset mid-sequence discards the partial sequence without flagging an error.
- FSM states and transitions, taken on NEW_CODE only:
  - IDLE:
    - E0 → EXT; F0 → BRK; E1 → PAUSE (skip counter = 7).
    - 00, AA, EE, FA, FC, FD, FE, FF → discarded, stay in IDLE.
    - Any other byte → emit make {code, ext=0}.
  - EXT: F0 → EXT_BRK; E0/E1 → discarded, stay in EXT; any other byte → emit make {code, ext=1}, go to IDLE.
  - BRK: any byte except E0/F0/E1 → emit break {code, ext=0}, go to IDLE; a prefix byte → discarded, stay in BRK.
  - EXT_BRK: any byte except a prefix → emit break {code, ext=1}, go to IDLE; a prefix byte → discarded, stay in EXT_BRK.
  - PAUSE: each byte decrements the skip counter; when it reaches 0 → emit one make {0x77, ext=1}, go to IDLE. No pause break event is ever emitted.
- Timeout:
  - A cycle counter clears on every NEW_CODE and runs in every non-IDLE state.
  - When it reaches TIMEOUT_CYC-1 → FSM goes to IDLE and TIMEOUT_ERR is set; no event is emitted.
- Repeat filter (FILTER_REPEAT=1):
  - Holds {code, ext} of the last emitted make.
  - A make equal to it is not pushed.
  - A break matching it clears the register.
  - A different make overwrites it.
- Latency:
  - Event emission occurs in the cycle after the NEW_CODE that completes the sequence.
  - With the FIFO empty, EVT_VALID rises 2 cycles after the final NEW_CODE.
- FIFO handshake:
  - Show-ahead: EVT_* present the head entry whenever EVT_VALID=1.
  - Pop occurs when EVT_VALID & EVT_READY.
  - EVT_READY while empty is ignored.
  - Push and pop in the same cycle: both happen, level unchanged. This also holds when the FIFO is full, so no drop occurs.
  - Push while full with no pop: the event is dropped, contents are unchanged, OVERFLOW is set.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - CLR_ERR clears both flags.
  - If CLR_ERR and a new error occur in the same cycle, the flag stays set (set wins).
- NEW_CODE pulses arrive at least 2 cycles apart; no back-pressure is applied to the receiver.

Decomposition:
- Shared package kbd_pkg holds:
  - Byte constants: PFX_EXT=8'hE0, PFX_BRK=8'hF0, PFX_PAUSE=8'hE1, the status-byte list, PAUSE_SKIP=7.
  - The FSM state encoding.
  - The event struct {release, ext, code[7:0]} (10 bits).
- One sub-module: kbd_evt_fifo (parameterised show-ahead synchronous FIFO, width 10, with level and full/empty outputs). The decoder FSM, timeout counter and repeat filter stay in the top.

Test Plan:
- Make then break of a plain key, EVT_READY held at 1: bytes 1C, F0 1C → two events {1C,ext0,rel0}, {1C,ext0,rel1}; the first EVT_VALID rises 2 cycles after the 1C pulse.
- Extended key: E0 75, E0 F0 75 → {75,ext1,rel0}, {75,ext1,rel1}. Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event {77,ext1,rel0}.
- Typematic filter: 1C 1C 1C F0 1C 1C → events make 1C, break 1C, make 1C (3 events total). Bytes AA, FA in IDLE → no event.
- Overflow with EVT_READY=0 and FIFO_DEPTH=4: five distinct makes → FIFO_LEVEL=4, OVERFLOW=1. Draining returns the first four codes in order.
  - Then push with simultaneous pop at full → no drop, level stays 4.
  - CLR_ERR → OVERFLOW=0.
- Timeout with TIMEOUT_CYC=100: E0, then silence for 100 cycles → TIMEOUT_ERR=1, FSM back in IDLE. A following 1C → {1C,ext0}.
- Asynchronous reset asserted between F0 and the code byte → all outputs are at reset values immediately. The byte 1C after release → make {1C,ext0,rel0}, not a break.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared byte constants, decoder state encoding and event record for the keyboard event controller
package kbd_pkg;
  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;
  localparam logic [7:0] PAUSE_CODE = 8'h77;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;
  localparam int         EVT_W      = 10;
  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_PAUSE} state_t;
  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } kbd_evt_t;
  function automatic logic is_prefix(input logic [7:0] b);
    return b == PFX_EXT || b == PFX_BRK || b == PFX_PAUSE;
  endfunction
  function automatic logic is_status(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  endfunction
endpackage

// File: rtl/kbd_event_ctrl_if.sv
// kbd_event_ctrl_if: receiver byte input, event valid/ready output, level and sticky error flags
interface kbd_event_ctrl_if #(parameter int FIFO_DEPTH = 4);
  logic                          NEW_CODE;
  logic [7:0]                    CODE;
  logic                          EVT_READY;
  logic                          EVT_VALID;
  logic [7:0]                    EVT_CODE;
  logic                          EVT_EXT;
  logic                          EVT_RELEASE;
  logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL;
  logic                          OVERFLOW;
  logic                          TIMEOUT_ERR;
  logic                          CLR_ERR;
  modport slave (
    input  NEW_CODE, CODE, EVT_READY, CLR_ERR,
    output EVT_VALID, EVT_CODE, EVT_EXT, EVT_RELEASE, FIFO_LEVEL, OVERFLOW, TIMEOUT_ERR
  );
  modport master (
    output NEW_CODE, CODE, EVT_READY, CLR_ERR,
    input  EVT_VALID, EVT_CODE, EVT_EXT, EVT_RELEASE, FIFO_LEVEL, OVERFLOW, TIMEOUT_ERR
  );
endinterface

// File: rtl/kbd_evt_fifo.sv
// kbd_evt_fifo: show-ahead synchronous FIFO with level/full/empty
//   clk, rst_n : clock, async active-low reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : consume head (ignored when empty)
//   dout       : head entry, zero when empty
//   empty, full, level : occupancy status
module kbd_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  level
);
  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic          do_pop, do_push;
  always_comb begin
    do_pop  = pop & ~empty;
    // a pop frees the slot, so a push at full still lands
    do_push = push & (~full | do_pop);
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    lvl_d   = (do_push && !do_pop) ? lvl_q + 1'b1 : (do_pop && !do_push) ? lvl_q - 1'b1 : lvl_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      lvl_q <= lvl_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_q] <= din;
  assign empty = lvl_q == '0;
  assign full  = lvl_q == LVL_MAX;
  assign level = lvl_q;
  assign dout  = empty ? '0 : mem[rd_q];
endmodule

// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: decodes keyboard scan-code bytes into make/break events and queues them
//   CLK, RST : clock, async active-low reset
//   bus      : byte input (NEW_CODE/CODE), event output (EVT_*), FIFO_LEVEL, sticky OVERFLOW/TIMEOUT_ERR, CLR_ERR
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_CYC   = 1000000,
  parameter int FILTER_REPEAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  kbd_event_ctrl_if.slave   bus
);
  localparam int            TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  kbd_evt_t      evt_q, evt_d, dec, head;
  logic          push_q, push_d, emit, match, tmo_hit;
  logic          rpt_vld_q, rpt_vld_d;
  logic [8:0]    rpt_q, rpt_d;
  logic          ovf_q, ovf_d, terr_q, terr_d;
  logic          empty, full;
  logic [7:0]    byte_in;
  assign byte_in = bus.CODE;
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    dec     = '0;
    tmo_hit = state_q != ST_IDLE && !bus.NEW_CODE && tmo_q == TMO_LAST;
    tmo_d   = (bus.NEW_CODE || state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
    if (bus.NEW_CODE)
      case (state_q)
        ST_IDLE: begin
          state_d = byte_in == PFX_EXT ? ST_EXT : byte_in == PFX_BRK ? ST_BRK :
                    byte_in == PFX_PAUSE ? ST_PAUSE : ST_IDLE;
          skip_d  = PAUSE_SKIP;
          emit    = !is_prefix(byte_in) && !is_status(byte_in);
          dec     = '{rel: 1'b0, ext: 1'b0, code: byte_in};
        end
        ST_EXT: begin
          state_d = byte_in == PFX_BRK ? ST_EXT_BRK : is_prefix(byte_in) ? ST_EXT : ST_IDLE;
          emit    = !is_prefix(byte_in);
          dec     = '{rel: 1'b0, ext: 1'b1, code: byte_in};
        end
        ST_BRK, ST_EXT_BRK: begin
          emit    = !is_prefix(byte_in);
          state_d = emit ? ST_IDLE : state_q;
          dec     = '{rel: 1'b1, ext: state_q == ST_EXT_BRK, code: byte_in};
        end
        ST_PAUSE: begin
          skip_d  = skip_q - 1'b1;
          emit    = skip_q == 3'd1;
          state_d = emit ? ST_IDLE : ST_PAUSE;
          dec     = '{rel: 1'b0, ext: 1'b1, code: PAUSE_CODE};
        end
        default: state_d = ST_IDLE;
      endcase
    if (tmo_hit) state_d = ST_IDLE;
    // repeat filter: remembers the last make until its matching break
    match     = rpt_vld_q && rpt_q == {dec.ext, dec.code};
    push_d    = emit && !(!dec.rel && match && FILTER_REPEAT != 0);
    rpt_vld_d = rpt_vld_q;
    rpt_d     = rpt_q;
    if (emit && !dec.rel) begin
      rpt_vld_d = 1'b1;
      rpt_d     = {dec.ext, dec.code};
    end else if (emit && match) rpt_vld_d = 1'b0;
    evt_d  = dec;
    ovf_d  = (ovf_q & ~bus.CLR_ERR) | (push_q & full & ~bus.EVT_READY);
    terr_d = (terr_q & ~bus.CLR_ERR) | tmo_hit;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q   <= ST_IDLE;
      skip_q    <= '0;
      tmo_q     <= '0;
      evt_q     <= '0;
      push_q    <= 1'b0;
      rpt_vld_q <= 1'b0;
      rpt_q     <= '0;
      ovf_q     <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      tmo_q     <= tmo_d;
      evt_q     <= evt_d;
      push_q    <= push_d;
      rpt_vld_q <= rpt_vld_d;
      rpt_q     <= rpt_d;
      ovf_q     <= ovf_d;
      terr_q    <= terr_d;
    end
  kbd_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push_q),
    .din   (evt_q),
    .pop   (bus.EVT_READY),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .level (bus.FIFO_LEVEL)
  );
  assign bus.EVT_VALID   = ~empty;
  assign bus.EVT_CODE    = head.code;
  assign bus.EVT_EXT     = head.ext;
  assign bus.EVT_RELEASE = head.rel;
  assign bus.OVERFLOW    = ovf_q;
  assign bus.TIMEOUT_ERR = terr_q;
endmodule
